skein_ubi_sequencer: RTL and testbench

- Sequences one Skein-1024-1024 hash of a fixed 20-byte message through a shared Threefish-1024 core.
- Pass 1 is the message UBI: key = config IV, tweak mode MSG.
- Pass 2 is the output UBI: key = chain value, plaintext = 0, tweak mode OUT.
- Sits between the candidate-message generator (upstream) and the Hamming-distance scorer (downstream). Drives the mode select of the tweak generator and the Threefish start/done handshake.

---
 rtl/skein_pkg.sv | 30 +++
 rtl/skein_ubi_sequencer.sv | 155 +++++++++++++++
 tb/tb_skein_ubi_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skein_pkg.sv
// Shared Skein-1024 constants and the UBI sequencer state type.
package skein_pkg;

  // Chain value produced by the Skein-1024 config UBI for a 1024-bit output.
  // Word 0 occupies bits [63:0].
  localparam logic [1023:0] SKEIN1024_IV_1024 = {
    64'h1DE0536E8682E539, 64'h61FD3062D00A579A,
    64'h6572DD22F2B4969A, 64'h0996753C10ED0BB8,
    64'h1A1F1DDE743F02D4, 64'h9243C60DCCFF1332,
    64'h6A9B0BFC6EB67E0D, 64'hD6D14AF9C6329AB5,
    64'hC11E1DB524DCB0A3, 64'h77E2BDFDC6394ADA,
    64'h6E510B8BCDD0589F, 64'h1CAEC6FD1983A898,
    64'h03BD41D3FCBCAFAF, 64'h5180E5AEBAF2C4F0,
    64'h15B5E511AC73E00C, 64'hD593DA0741E72355
  };

  // Tweak generator mode select.
  localparam logic TWEAK_MODE_MSG = 1'b0;
  localparam logic TWEAK_MODE_OUT = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MSG_START = 3'd1,
    MSG_WAIT  = 3'd2,
    OUT_START = 3'd3,
    OUT_WAIT  = 3'd4,
    HOLD      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/skein_ubi_sequencer.sv
// Runs the message UBI and the output UBI of one Skein-1024-1024 hash
// through a shared Threefish-1024 core, then holds the digest for the scorer.
module skein_ubi_sequencer
  import skein_pkg::*;
#(
  parameter int BLOCK_W   = 1024,
  parameter int MSG_BYTES = 20,
  parameter int MAX_WAIT  = 4095
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   tf_mode,
  output logic [BLOCK_W-1:0]     tf_key,
  output logic [BLOCK_W-1:0]     tf_plain,
  output logic                   tf_start,
  input  logic                   tf_done,
  input  logic [BLOCK_W-1:0]     tf_cipher,
  output logic                   hash_valid,
  input  logic                   hash_ready,
  output logic [BLOCK_W-1:0]     hash_data,
  output logic [31:0]            hash_count,
  output logic                   err
);

  localparam int TMR_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  // Timer value seen during the last permitted wait cycle.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_WAIT - 1);
  localparam logic [BLOCK_W-1:0] IV = BLOCK_W'(SKEIN1024_IV_1024);

  seq_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] pad_q, pad_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] hash_q, hash_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               err_q, err_d;

  // State and datapath registers; reset aborts any hash in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pad_q   <= '0;
      chain_q <= '0;
      hash_q  <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      chain_q <= chain_d;
      hash_q  <= hash_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath updates and core/handshake outputs.
  always_comb begin
    state_d    = state_q;
    pad_d      = pad_q;
    chain_d    = chain_q;
    hash_d     = hash_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    err_d      = err_q;
    msg_ready  = 1'b0;
    tf_start   = 1'b0;
    tf_mode    = TWEAK_MODE_MSG;
    tf_key     = '0;
    tf_plain   = '0;
    hash_valid = 1'b0;

    // A completion pulse is only meaningful while a pass is outstanding.
    if (tf_done && (state_q != MSG_WAIT) && (state_q != OUT_WAIT)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        msg_ready = rst_n;
        if (msg_valid) begin
          pad_d   = BLOCK_W'(msg_data);
          state_d = MSG_START;
        end
      end
      MSG_START: begin
        tf_start = 1'b1;
        tf_key   = IV;
        tf_plain = pad_q;
        timer_d  = '0;
        state_d  = MSG_WAIT;
      end
      MSG_WAIT: begin
        tf_key   = IV;
        tf_plain = pad_q;
        // Completion wins over a timeout landing in the same cycle.
        if (tf_done) begin
          chain_d = tf_cipher ^ pad_q;
          state_d = OUT_START;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OUT_START: begin
        tf_start = 1'b1;
        tf_mode  = TWEAK_MODE_OUT;
        tf_key   = chain_q;
        timer_d  = '0;
        state_d  = OUT_WAIT;
      end
      OUT_WAIT: begin
        tf_mode = TWEAK_MODE_OUT;
        tf_key  = chain_q;
        // Output UBI plaintext is zero, so the feed-forward XOR is a no-op.
        if (tf_done) begin
          hash_d  = tf_cipher;
          state_d = HOLD;
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        hash_valid = 1'b1;
        msg_ready  = rst_n & hash_ready;
        if (hash_ready) begin
          cnt_d = cnt_q + 32'd1;
          // Back-to-back accept skips the idle cycle.
          if (msg_valid) begin
            pad_d   = BLOCK_W'(msg_data);
            state_d = MSG_START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hash_data  = hash_q;
  assign hash_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_skein_ubi_sequencer.sv
// Bench for skein_ubi_sequencer with a stub Threefish core (cipher = key).
module tb_skein_ubi_sequencer;
  import skein_pkg::*;

  localparam int BW  = 1024;
  localparam int MB  = 20;
  localparam int MW  = 15;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            msg_valid = 1'b0;
  logic            msg_ready;
  logic [8*MB-1:0] msg_data = '0;
  logic            tf_mode;
  logic [BW-1:0]   tf_key;
  logic [BW-1:0]   tf_plain;
  logic            tf_start;
  logic            tf_done;
  logic [BW-1:0]   tf_cipher;
  logic            hash_valid;
  logic            hash_ready = 1'b0;
  logic [BW-1:0]   hash_data;
  logic [31:0]     hash_count;
  logic            err;

  always #5 clk = ~clk;

  skein_ubi_sequencer #(.BLOCK_W(BW), .MSG_BYTES(MB), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .tf_mode(tf_mode), .tf_key(tf_key), .tf_plain(tf_plain),
    .tf_start(tf_start), .tf_done(tf_done), .tf_cipher(tf_cipher),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_data(hash_data),
    .hash_count(hash_count), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int w;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      w = 0;
      for (int i = 15; i >= 0; i--) if (act[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
      $display("FAIL %s: got word%0d=%h, expected %h", nm, w, act[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event within bound, expected event", nm);
  endtask

  // Stub core: latches key on start, pulses done LAT cycles after start.
  logic          stub_en = 1'b1;
  logic          spur = 1'b0;
  logic          stub_done;
  int            stub_cnt;
  logic [BW-1:0] key_lat;
  assign tf_done   = stub_done | spur;
  assign tf_cipher = key_lat;

  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (!rst_n) begin
      stub_cnt <= 0;
      key_lat  <= '0;
    end else if (tf_start) begin
      stub_cnt <= LAT - 1;
      key_lat  <= tf_key;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && stub_en) stub_done <= 1'b1;
    end
  end

  // Transaction model: with cipher = key, chain = IV ^ pad and digest = IV ^ pad.
  bit            mon_en = 1'b1;
  int            cyc = 0;
  logic [BW-1:0] exp_q[$];
  int            acc_q[$];
  logic [BW-1:0] cur_pad;
  int            starts, exp_cnt;
  bit            in_flight, prev_start, prev_valid, prev_ready, valid_seen;
  logic [BW-1:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      cur_pad = '0; starts = 0; exp_cnt = 0;
      in_flight = 0; valid_seen = 0;
    end else if (mon_en) begin
      chk("tf_start_single_cycle", BW'(prev_start & tf_start), '0);
      chk("msg_ready", BW'(msg_ready), BW'(in_flight ? (hash_valid & hash_ready) : 1'b1));
      chk("hash_count", BW'(hash_count), BW'(exp_cnt));
      if (hash_valid) begin
        if (exp_q.size() == 0) bound_fail("hash_valid_without_message");
        else begin
          chk("hash_data", hash_data, exp_q[0]);
          if (!valid_seen) chk("latency", BW'(cyc - acc_q[0] + 1), BW'(4 + 2*LAT));
          valid_seen = 1;
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", BW'(hash_valid), BW'(1'b1));
        chk("hold_data", hash_data, prev_data);
      end
      if (tf_start) begin
        if (starts == 0) begin
          chk("msg_pass_mode", BW'(tf_mode), BW'(TWEAK_MODE_MSG));
          chk("msg_pass_key", tf_key, SKEIN1024_IV_1024);
          chk("msg_pass_plain", tf_plain, cur_pad);
        end else if (starts == 1) begin
          chk("out_pass_mode", BW'(tf_mode), BW'(TWEAK_MODE_OUT));
          chk("out_pass_key", tf_key, SKEIN1024_IV_1024 ^ cur_pad);
          chk("out_pass_plain", tf_plain, '0);
        end else bound_fail("extra_tf_start");
        starts++;
      end else if (stub_cnt > 0) begin
        chk("wait_key_stable", tf_key, key_lat);
      end
      if (hash_valid && hash_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        exp_cnt++;
        valid_seen = 0;
        in_flight  = 0;
      end
      if (msg_valid && msg_ready) begin
        cur_pad = BW'(msg_data);
        exp_q.push_back(SKEIN1024_IV_1024 ^ BW'(msg_data));
        acc_q.push_back(cyc);
        starts    = 0;
        in_flight = 1;
      end
    end
    prev_start = tf_start;
    prev_valid = hash_valid;
    prev_ready = hash_ready;
    prev_data  = hash_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a message and hold it until accepted; optionally keep valid high.
  task automatic send(input logic [8*MB-1:0] d, input bit keep);
    int n;
    msg_data  = d;
    msg_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!msg_ready && n < 200);
    if (!msg_ready) bound_fail("msg_accept");
    tick();
    if (!keep) msg_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hash_valid && n < 100);
    if (!hash_valid) bound_fail(nm);
  endtask

  task automatic take_hash();
    tick();
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int n_starts;
  bit mode_seq[2];
  logic [BW-1:0] out_key;

  initial begin
    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tf_start", BW'(tf_start), '0);
    chk("rst_tf_mode", BW'(tf_mode), '0);
    chk("rst_hash_valid", BW'(hash_valid), '0);
    chk("rst_err", BW'(err), '0);
    chk("rst_hash_count", BW'(hash_count), '0);
    chk("rst_msg_ready", BW'(msg_ready), '0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_msg_ready", BW'(msg_ready), BW'(1'b1));

    // Zero message: digest is the IV itself
    tick();
    send('0, 1'b0);
    wait_valid("zero_msg_valid");
    chk("zero_digest_w0", BW'(hash_data[63:0]), BW'(64'hD593DA0741E72355));
    chk("zero_digest_w15", BW'(hash_data[1023:960]), BW'(64'h1DE0536E8682E539));
    chk("zero_err", BW'(err), '0);
    take_hash();
    @(negedge clk);
    chk("count_after_first", BW'(hash_count), BW'(32'd1));

    // Message 1: two start pulses, MSG then OUT, OUT key = IV ^ 1
    tick();
    send(160'h1, 1'b0);
    n_starts = 0;
    out_key = '0;
    for (int i = 0; i < 40 && !hash_valid; i++) begin
      @(negedge clk);
      if (tf_start) begin
        if (n_starts < 2) mode_seq[n_starts] = tf_mode;
        if (tf_mode) out_key = tf_key;
        n_starts++;
      end
    end
    chk("start_pulses", BW'(n_starts), BW'(2));
    chk("first_pass_mode", BW'(mode_seq[0]), BW'(1'b0));
    chk("second_pass_mode", BW'(mode_seq[1]), BW'(1'b1));
    chk("out_key_w0", BW'(out_key[63:0]), BW'(64'hD593DA0741E72354));
    take_hash();

    // Backpressure for 20 cycles, then back-to-back accept
    tick();
    send(160'h2, 1'b0);
    wait_valid("bp_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_msg_ready", BW'(msg_ready), '0);
    end
    tick();
    hash_ready = 1'b1;
    msg_valid  = 1'b1;
    msg_data   = 160'h3;
    @(negedge clk);
    chk("b2b_msg_ready", BW'(msg_ready), BW'(1'b1));
    tick();
    hash_ready = 1'b0;
    msg_valid  = 1'b0;
    @(negedge clk);
    chk("b2b_start", BW'(tf_start), BW'(1'b1));
    chk("b2b_plain", tf_plain, BW'(160'h3));
    wait_valid("b2b_valid");
    take_hash();
    @(negedge clk);
    chk("count_after_b2b", BW'(hash_count), BW'(32'd4));

    // Timeout: core never completes
    mon_en  = 1'b0;
    stub_en = 1'b0;
    tick();
    send(160'h5, 1'b0);
    @(negedge clk);
    chk("to_start", BW'(tf_start), BW'(1'b1));
    repeat (MW) @(posedge clk);
    @(negedge clk);
    chk("to_err_before", BW'(err), '0);
    @(posedge clk);
    @(negedge clk);
    chk("to_err_after", BW'(err), BW'(1'b1));
    chk("to_idle", BW'(msg_ready), BW'(1'b1));
    repeat (5) @(negedge clk);
    chk("to_no_hash", BW'(hash_valid), '0);
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", BW'(err), '0);

    // Spurious done in IDLE
    stub_en = 1'b1;
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    @(negedge clk);
    chk("spur_err", BW'(err), BW'(1'b1));
    chk("spur_idle", BW'(msg_ready), BW'(1'b1));
    chk("spur_no_start", BW'(tf_start), '0);
    do_reset();

    // Reset during OUT_WAIT
    tick();
    send(160'h7, 1'b0);
    for (int i = 0; i < 40 && !(tf_start && tf_mode); i++) @(negedge clk);
    if (!(tf_start && tf_mode)) bound_fail("out_start_seen");
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_tf_start", BW'(tf_start), '0);
    chk("abort_tf_mode", BW'(tf_mode), '0);
    chk("abort_tf_key", tf_key, '0);
    chk("abort_tf_plain", tf_plain, '0);
    chk("abort_hash_valid", BW'(hash_valid), '0);
    chk("abort_hash_data", hash_data, '0);
    chk("abort_err", BW'(err), '0);
    chk("abort_msg_ready", BW'(msg_ready), '0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 100 back-to-back messages
    hash_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(160'h4141414141414141414141414141414141414141 ^ 160'(i), 1'b1);
    end
    msg_valid = 1'b0;
    for (int i = 0; i < 100 && hash_count != 32'd100; i++) @(negedge clk);
    chk("count_100", BW'(hash_count), BW'(32'd100));
    chk("final_err", BW'(err), '0);
    hash_ready = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got no end of test, expected end before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
